// File: rtl/prescaled_counter.sv
// Prescaled modulo-N up/down counter: a programmable prescaler yields a one-cycle tick
// that steps a wrap/saturate counter with terminal-count and heartbeat outputs.
module prescaled_counter #(
   parameter int unsigned CNT_W    = 9,
   parameter int unsigned PRE_W    = 25,
   parameter int unsigned PRE_DIV  = 25000000,
   parameter int unsigned CNT_MAX  = 511,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_b,
   input  logic             dir,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             tick,
   output logic             tc,
   output logic             heartbeat
);

   if (PRE_DIV == 0) begin : g_bad_pre_div_zero
      $error("prescaled_counter: PRE_DIV must be at least 1");
   end
   if ((PRE_DIV >> PRE_W) != 0) begin : g_bad_pre_div_wide
      $error("prescaled_counter: PRE_DIV does not fit in PRE_W bits");
   end
   if ((CNT_MAX >> CNT_W) != 0) begin : g_bad_cnt_max
      $error("prescaled_counter: CNT_MAX does not fit in CNT_W bits");
   end

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             tc_q, tc_d;
   logic             hb_q, hb_d;

   logic             step;
   logic             at_top, at_zero;
   logic [CNT_W-1:0] load_clamped;
   logic [CNT_W-1:0] cnt_up, cnt_dn;

   // The wrap edge of the prescaler is the only edge that can advance the count.
   assign step    = ~en_b & (pre_q == PRE_LAST);
   assign at_top  = (cnt_q == CNT_TOP);
   assign at_zero = (cnt_q == '0);

   assign load_clamped = (load_val > CNT_TOP) ? CNT_TOP : load_val;

   always_comb begin
      cnt_up = cnt_q + CNT_W'(1);
      if (at_top) begin
         cnt_up = SATURATE ? CNT_TOP : '0;
      end
   end

   always_comb begin
      cnt_dn = cnt_q - CNT_W'(1);
      if (at_zero) begin
         cnt_dn = SATURATE ? '0 : CNT_TOP;
      end
   end

   always_comb begin
      pre_d = pre_q;
      if (clr) begin
         pre_d = '0;
      end else if (!en_b) begin
         pre_d = step ? '0 : pre_q + PRE_W'(1);
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      tc_d   = 1'b0;
      hb_d   = hb_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         // A load on a step edge swallows that step entirely.
         cnt_d = load_clamped;
      end else if (step) begin
         tick_d = 1'b1;
         hb_d   = ~hb_q;
         if (dir) begin
            cnt_d = cnt_up;
            tc_d  = at_top;
         end else begin
            cnt_d = cnt_dn;
            tc_d  = at_zero;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q  <= '0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         tc_q   <= 1'b0;
         hb_q   <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         tc_q   <= tc_d;
         hb_q   <= hb_d;
      end
   end

   assign cnt       = cnt_q;
   assign tick      = tick_q;
   assign tc        = tc_q;
   assign heartbeat = hb_q;

   tc_implies_tick: assert property (@(posedge clk) disable iff (rst) tc_q |-> tick_q);
   cnt_in_range:    assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_TOP);

endmodule

// File: tb/tb_prescaled_counter.sv
// Randomised bench for prescaled_counter: wrap and saturate instances driven in parallel
// and checked every cycle against an arithmetic model, plus directed literal checks.
module tb_prescaled_counter;

   localparam int CW = 4;
   localparam int PW = 4;
   localparam int PD = 4;
   localparam int CM = 9;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          en_b     = 1'b1;
   logic          dir      = 1'b1;
   logic          clr      = 1'b0;
   logic          load     = 1'b0;
   logic [CW-1:0] load_val = '0;

   logic [CW-1:0] cnt_w, cnt_s;
   logic          tick_w, tick_s, tc_w, tc_s, hb_w, hb_s;

   int checks   = 0;
   int failures = 0;
   int n_tick   = 0;
   int n_tc_w   = 0;
   int n_tc_s   = 0;

   // Model state: index 0 = wrapping instance, 1 = saturating instance.
   int m_pre     = 0;
   int m_cnt[2]  = '{0, 0};
   int m_tick[2] = '{0, 0};
   int m_tc[2]   = '{0, 0};
   int m_hb[2]   = '{0, 0};
   logic m_step;

   always #5 clk = ~clk;

   prescaled_counter #(
      .CNT_W(CW), .PRE_W(PW), .PRE_DIV(PD), .CNT_MAX(CM), .SATURATE(1'b0)
   ) u_wrap (
      .clk(clk), .rst(rst), .en_b(en_b), .dir(dir), .clr(clr), .load(load),
      .load_val(load_val), .cnt(cnt_w), .tick(tick_w), .tc(tc_w), .heartbeat(hb_w)
   );

   prescaled_counter #(
      .CNT_W(CW), .PRE_W(PW), .PRE_DIV(PD), .CNT_MAX(CM), .SATURATE(1'b1)
   ) u_sat (
      .clk(clk), .rst(rst), .en_b(en_b), .dir(dir), .clr(clr), .load(load),
      .load_val(load_val), .cnt(cnt_s), .tick(tick_s), .tc(tc_s), .heartbeat(hb_s)
   );

   function automatic int next_cnt(input int cur, input logic up, input int sat);
      if (up) return sat != 0 ? ((cur + 1 > CM) ? CM : cur + 1) : (cur + 1) % (CM + 1);
      return sat != 0 ? ((cur == 0) ? 0 : cur - 1) : (cur + CM) % (CM + 1);
   endfunction

   assign m_step = !en_b && (m_pre == PD - 1);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pre <= 0;
         for (int s = 0; s < 2; s++) begin
            m_cnt[s] <= 0; m_tick[s] <= 0; m_tc[s] <= 0; m_hb[s] <= 0;
         end
      end else begin
         m_pre <= clr ? 0 : (!en_b ? (m_pre + 1) % PD : m_pre);
         for (int s = 0; s < 2; s++) begin
            if (clr) begin
               m_cnt[s] <= 0; m_tick[s] <= 0; m_tc[s] <= 0;
            end else if (load) begin
               m_cnt[s]  <= (int'(load_val) > CM) ? CM : int'(load_val);
               m_tick[s] <= 0; m_tc[s] <= 0;
            end else if (m_step) begin
               m_cnt[s]  <= next_cnt(m_cnt[s], dir, s);
               m_tick[s] <= 1;
               m_tc[s]   <= (dir ? (m_cnt[s] == CM) : (m_cnt[s] == 0)) ? 1 : 0;
               m_hb[s]   <= 1 - m_hb[s];
            end else begin
               m_tick[s] <= 0; m_tc[s] <= 0;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("wrap.cnt", int'(cnt_w), m_cnt[0]);
      chk("wrap.tick", int'(tick_w), m_tick[0]);
      chk("wrap.tc", int'(tc_w), m_tc[0]);
      chk("wrap.hb", int'(hb_w), m_hb[0]);
      chk("sat.cnt", int'(cnt_s), m_cnt[1]);
      chk("sat.tick", int'(tick_s), m_tick[1]);
      chk("sat.tc", int'(tc_s), m_tc[1]);
      chk("sat.hb", int'(hb_s), m_hb[1]);
      if (tick_w) n_tick++;
      if (tc_w) n_tc_w++;
      if (tc_s) n_tc_s++;
   end

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      edges(2);
      rst = 1'b0;
      chk("reset.cnt", int'(cnt_w), 0);
      chk("reset.tick", int'(tick_w), 0);
      chk("reset.hb", int'(hb_w), 0);

      // Free-run up for 44 cycles: 11 ticks, one wrap at 9->0.
      en_b = 1'b0; n_tick = 0; n_tc_w = 0; n_tc_s = 0;
      edges(44);
      @(negedge clk); #1;
      chk("run.ticks", n_tick, 11);
      chk("run.tc_wrap", n_tc_w, 1);
      chk("run.tc_sat", n_tc_s, 2);
      chk("run.cnt_wrap", int'(cnt_w), 1);
      chk("run.cnt_sat", int'(cnt_s), 9);
      chk("run.hb", int'(hb_w), 1);

      // Down from zero.
      clr = 1'b1; edges(1);
      clr = 1'b0; dir = 1'b0;
      edges(3);
      chk("down.no_tick_early", int'(tick_w), 0);
      edges(1);
      chk("down.cnt_wrap", int'(cnt_w), 9);
      chk("down.tc_wrap", int'(tc_w), 1);
      chk("down.cnt_sat", int'(cnt_s), 0);
      chk("down.tc_sat", int'(tc_s), 1);

      // Pause mid-period; the remaining two cycles resume afterwards.
      edges(2);
      en_b = 1'b1; n_tick = 0;
      edges(10);
      chk("pause.ticks", n_tick, 0);
      chk("pause.cnt", int'(cnt_w), 9);
      en_b = 1'b0;
      edges(1);
      chk("resume.tick1", int'(tick_w), 0);
      edges(1);
      chk("resume.tick2", int'(tick_w), 1);
      chk("resume.cnt", int'(cnt_w), 8);

      // Load on a step edge, then a clamped load.
      edges(3);
      load = 1'b1; load_val = 4'd7;
      edges(1);
      chk("load.cnt", int'(cnt_w), 7);
      chk("load.tick", int'(tick_w), 0);
      load_val = 4'd15;
      edges(1);
      chk("load.clamp", int'(cnt_w), 9);

      // clr beats load and restarts the prescaler.
      load_val = 4'd5;
      edges(1);
      chk("clrload.pre", int'(cnt_w), 5);
      clr = 1'b1;
      edges(1);
      chk("clrload.cnt", int'(cnt_w), 0);
      clr = 1'b0; load = 1'b0; dir = 1'b1;
      edges(3);
      chk("clrload.no_tick", int'(tick_w), 0);
      edges(1);
      chk("clrload.tick", int'(tick_w), 1);
      chk("clrload.cnt1", int'(cnt_w), 1);

      repeat (1500) begin
         en_b     = ($urandom_range(0, 9) < 3);
         dir      = 1'($urandom);
         clr      = ($urandom_range(0, 31) == 0);
         load     = ($urandom_range(0, 15) == 0);
         load_val = 4'($urandom);
         edges(1);
      end

      // Asynchronous reset between edges.
      clr = 1'b0; en_b = 1'b0; load = 1'b1; load_val = 4'd6;
      edges(1);
      load = 1'b0; en_b = 1'b1;
      edges(1);
      chk("arst.before", int'(cnt_w), 6);
      #3;
      rst = 1'b1;
      #1;
      chk("arst.cnt_wrap", int'(cnt_w), 0);
      chk("arst.cnt_sat", int'(cnt_s), 0);
      chk("arst.tick", int'(tick_w), 0);
      chk("arst.tc", int'(tc_w), 0);
      chk("arst.hb", int'(hb_w), 0);
      edges(2);
      rst = 1'b0;
      edges(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
Parametrised prescaled up/down counter for board-level demos and LED/7-seg drivers. A programmable prescaler divides clk to a one-cycle tick. The tick advances a modulo-N counter with direction, synchronous load/clear, wrap or saturate mode, and terminal-count/heartbeat outputs. It replaces the fixed 32-bit free-running counter plus bit-tap approach. The active-low button enable is retained.

Parameters:
CNT_W, 9, width of the visible count.
PRE_W, 25, prescaler register width.
PRE_DIV, 25000000, clk cycles per tick; legal range 1..2^PRE_W-1.
CNT_MAX, 511, highest count value; count range is 0..CNT_MAX; CNT_MAX <= 2^CNT_W-1.
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  reset; asynchronous, active-high.
en_b  in  1  count enable, active-low (button idles high = paused).
dir  in  1  1 = count up, 0 = count down.
clr  in  1  synchronous clear, active-high.
load  in  1  synchronous load, active-high.
load_val  in  CNT_W  value to load.
cnt  out  CNT_W  current count (registered).
tick  out  1  registered one-cycle pulse per prescaler period.
tc  out  1  registered one-cycle terminal-count pulse.
heartbeat  out  1  toggles on every tick (50% duty when free-running).

Behaviour:
- Reset (async, rst=1): prescaler=0, cnt=0, tick=0, tc=0, heartbeat=0. Outputs are held while rst is high. The first update occurs on the first rising edge after rst falls.
- Prescaler:
  - Advances only when en_b=0; holds its value when en_b=1.
  - Counts 0..PRE_DIV-1, then returns to 0. That wrap edge is the "step edge".
  - PRE_DIV=1: every enabled cycle is a step edge.
- Priority per edge: clr > load > step.
- clr=1:
  - prescaler<=0, cnt<=0, tick<=0, tc<=0; heartbeat is unchanged.
  - Applies regardless of en_b.
- load=1 (clr=0):
  - cnt<=load_val, or CNT_MAX if load_val > CNT_MAX.
  - Prescaler continues per en_b.
  - tick/tc<=0 on this edge, even if it is a step edge; the step is discarded.
- Step edge (clr=0, load=0):
  - tick<=1 for exactly the next cycle; heartbeat toggles.
  - Up (dir=1):
    - cnt<CNT_MAX: cnt<=cnt+1.
    - cnt==CNT_MAX: cnt<=0 (SATURATE=0) or cnt<=CNT_MAX (SATURATE=1); tc<=1.
  - Down (dir=0):
    - cnt>0: cnt<=cnt-1.
    - cnt==0: cnt<=CNT_MAX (SATURATE=0) or cnt<=0 (SATURATE=1); tc<=1.
  - tc is asserted in the same cycle as tick and never without tick.
- Non-step edges: tick<=0, tc<=0; cnt holds.
- Latency:
  - cnt, tick and tc change together, one edge after the final prescaler count.
  - Changing dir takes effect on the next step edge. dir is sampled only at step edges.
- en_b deasserted mid-period: prescaler freezes. The remaining period resumes when en_b returns low; the period is not restarted.
- All arithmetic is unsigned, with no overflow beyond CNT_W. Non-power-of-two CNT_MAX must wrap exactly at CNT_MAX.
- Elaboration check: error if PRE_DIV==0, PRE_DIV>=2^PRE_W, or CNT_MAX>=2^CNT_W.

Test Plan:
(Bench parameters: CNT_W=4, PRE_W=4, PRE_DIV=4, CNT_MAX=9, SATURATE=0 unless stated.)
- Reset then en_b=0, dir=1 for 44 cycles:
  - tick pulses every 4th cycle; cnt runs 1..9, 0, 1.
  - tc high only on the 9->0 tick; heartbeat toggles each tick.
- dir=0 from cnt=0 -> next tick gives cnt=9 with tc=1. With SATURATE=1 the same stimulus -> cnt stays 0, tc=1.
- en_b=1 after 2 prescaler cycles, held for 10 cycles, then en_b=0 -> next tick arrives 2 enabled cycles later; no ticks while paused.
- load=1, load_val=7 on a step edge -> cnt=7, tick=0 that cycle. Then load_val=15 -> cnt=9 (clamped).
- clr and load both high at cnt=5 -> cnt=0 and prescaler restarts; next tick arrives 4 enabled cycles later.
- rst asserted asynchronously mid-count (cnt=6, between clk edges) -> cnt=0, tick=0, tc=0, heartbeat=0 immediately.
